// File: rtl/interrupt_controller.sv
// Four-source fixed-priority interrupt arbiter with a request/ack/done trap handshake.
// Define INTC_EXT_SYNC_EN to add a 2-flop synchronizer on int_ext1/int_ext2.
module interrupt_controller (
   input  logic        clk,
   input  logic        reset,
   input  logic        int_ext1,
   input  logic        int_ext2,
   input  logic        tim1_irq,
   input  logic        tim2_irq,
   input  logic [1:0]  reg_addr,
   input  logic [31:0] reg_wdata,
   input  logic        reg_we,
   output logic [31:0] reg_rdata,
   output logic        irq_req,
   output logic [1:0]  irq_cause,
   input  logic        irq_ack,
   input  logic        irq_done
);
   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_REQUEST = 2'd1;
   localparam logic [1:0] ST_SERVICE = 2'd2;

`ifdef INTC_EXT_SYNC_EN
   localparam int STAGES = 4;
`else
   localparam int STAGES = 2;
`endif

   logic [1:0]  pin;
   logic [1:0]  ext_edge;
   logic [3:0]  enable_reg;
   logic [3:0]  pending_reg;
   logic [3:0]  pending_next;
   logic [3:0]  set_vec;
   logic [3:0]  w1c_vec;
   logic [3:0]  ack_vec;
   logic [3:0]  masked;
   logic        gie_reg;
   logic [1:0]  state_reg;
   logic [1:0]  cause_reg;
   logic [1:0]  winner;
   logic        req_reg;

   assign pin = {int_ext2, int_ext1};

   // The top two chain stages are the edge detector (s, s_prev). valid_reg
   // tracks which stages hold a real post-reset sample, so a pin that is
   // already high when reset releases never looks like a rising edge.
   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_ext
         logic [STAGES-1:0] chain_reg;
         logic [STAGES-1:0] valid_reg;

         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               chain_reg <= '0;
               valid_reg <= '0;
            end else begin
               chain_reg <= {chain_reg[STAGES-2:0], pin[gi]};
               valid_reg <= {valid_reg[STAGES-2:0], 1'b1};
            end
         end

         assign ext_edge[gi] = chain_reg[STAGES-2] & ~chain_reg[STAGES-1] & valid_reg[STAGES-1];
      end
   endgenerate

   assign set_vec      = {tim2_irq, tim1_irq, ext_edge};
   assign w1c_vec      = (reg_we && reg_addr == 2'd1) ? reg_wdata[3:0] : 4'h0;
   assign ack_vec      = (state_reg == ST_REQUEST && irq_ack) ? (4'b0001 << cause_reg) : 4'h0;
   // New events are ORed in last so they survive a same-cycle clear.
   assign pending_next = (pending_reg & ~w1c_vec & ~ack_vec) | set_vec;
   assign masked       = pending_reg & enable_reg;

   always_comb begin
      winner = 2'd0;
      for (int i = 3; i >= 0; i--) begin
         if (masked[i]) winner = 2'(i);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         enable_reg  <= 4'h0;
         pending_reg <= 4'h0;
         gie_reg     <= 1'b0;
         state_reg   <= ST_IDLE;
         cause_reg   <= 2'd0;
         req_reg     <= 1'b0;
      end else begin
         pending_reg <= pending_next;
         if (reg_we && reg_addr == 2'd0) enable_reg <= reg_wdata[3:0];
         if (reg_we && reg_addr == 2'd2) gie_reg <= reg_wdata[0];
         case (state_reg)
            ST_IDLE: begin
               if (gie_reg && (|masked)) begin
                  state_reg <= ST_REQUEST;
                  req_reg   <= 1'b1;
                  cause_reg <= winner;
               end
            end
            ST_REQUEST: begin
               if (irq_ack) begin
                  state_reg <= ST_SERVICE;
                  req_reg   <= 1'b0;
               end
            end
            ST_SERVICE: begin
               if (irq_done) state_reg <= ST_IDLE;
            end
            default: begin
               state_reg <= ST_IDLE;
               req_reg   <= 1'b0;
            end
         endcase
      end
   end

   always_comb begin
      reg_rdata = 32'h0;
      case (reg_addr)
         2'd0: reg_rdata[3:0] = enable_reg;
         2'd1: reg_rdata[3:0] = pending_reg;
         2'd2: reg_rdata[0]   = gie_reg;
         2'd3: reg_rdata[3:0] = {cause_reg, state_reg == ST_REQUEST, state_reg == ST_SERVICE};
         default: reg_rdata = 32'h0;
      endcase
   end

   assign irq_req   = req_reg;
   assign irq_cause = cause_reg;

endmodule

// File: tb/tb_interrupt_controller.sv
// Self-checking bench for interrupt_controller: directed plan steps plus a random phase,
// all checked every cycle against a behavioural model of the pending/request rules.
module tb_interrupt_controller;
`ifdef INTC_EXT_SYNC_EN
   localparam int LAT = 3;
`else
   localparam int LAT = 1;
`endif
   localparam int M_IDLE = 0;
   localparam int M_REQ  = 1;
   localparam int M_SVC  = 2;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        int_ext1 = 1'b0;
   logic        int_ext2 = 1'b0;
   logic        tim1_irq = 1'b0;
   logic        tim2_irq = 1'b0;
   logic [1:0]  reg_addr = 2'd0;
   logic [31:0] reg_wdata = 32'h0;
   logic        reg_we = 1'b0;
   logic [31:0] reg_rdata;
   logic        irq_req;
   logic [1:0]  irq_cause;
   logic        irq_ack = 1'b0;
   logic        irq_done = 1'b0;

   int total = 0;
   int bad = 0;

   logic [3:0] m_pend;
   logic [3:0] m_en;
   logic       m_gie;
   int         m_state;
   logic [1:0] m_cause;
   int         cyc;
   logic       h1[$];
   logic       h2[$];

   interrupt_controller dut (
      .clk(clk), .reset(reset),
      .int_ext1(int_ext1), .int_ext2(int_ext2),
      .tim1_irq(tim1_irq), .tim2_irq(tim2_irq),
      .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_we(reg_we), .reg_rdata(reg_rdata),
      .irq_req(irq_req), .irq_cause(irq_cause), .irq_ack(irq_ack), .irq_done(irq_done)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Pin value sampled at edge c lives at q[c-1]; a rise seen at edge t-LAT sets pending at edge t.
   function automatic logic rose(input int t, input logic q[$]);
      if (t - LAT - 1 < 1) return 1'b0;
      return q[t-LAT-1] & ~q[t-LAT-2];
   endfunction

   function automatic logic [1:0] lowest(input logic [3:0] v);
      for (int i = 0; i < 4; i++) begin
         if (v[i]) return 2'(i);
      end
      return 2'd0;
   endfunction

   task automatic rd(input logic [1:0] a, output logic [31:0] v);
      reg_addr = a;
      #1;
      v = reg_rdata;
   endtask

   task automatic step();
      logic [3:0]  evt, w1c, ackclr, hit, n_pend, n_en;
      logic        n_gie;
      int          n_state;
      logic [1:0]  n_cause;
      logic [31:0] v;
      cyc++;
      h1.push_back(int_ext1);
      h2.push_back(int_ext2);
      evt    = {tim2_irq, tim1_irq, rose(cyc, h2), rose(cyc, h1)};
      w1c    = (reg_we && reg_addr == 2'd1) ? reg_wdata[3:0] : 4'h0;
      ackclr = (m_state == M_REQ && irq_ack) ? (4'b0001 << m_cause) : 4'h0;
      n_pend = (m_pend & ~w1c & ~ackclr) | evt;
      n_en   = (reg_we && reg_addr == 2'd0) ? reg_wdata[3:0] : m_en;
      n_gie  = (reg_we && reg_addr == 2'd2) ? reg_wdata[0] : m_gie;
      n_state = m_state;
      n_cause = m_cause;
      hit = m_pend & m_en;
      if (m_state == M_IDLE && m_gie && hit != 4'h0) begin
         n_state = M_REQ;
         n_cause = lowest(hit);
      end else if (m_state == M_REQ && irq_ack) begin
         n_state = M_SVC;
      end else if (m_state == M_SVC && irq_done) begin
         n_state = M_IDLE;
      end
      @(posedge clk);
      #1;
      m_pend = n_pend; m_en = n_en; m_gie = n_gie; m_state = n_state; m_cause = n_cause;
      tim1_irq = 1'b0; tim2_irq = 1'b0; reg_we = 1'b0; reg_wdata = 32'h0;
      irq_ack = 1'b0; irq_done = 1'b0;
      check("irq_req", 32'(irq_req), 32'(m_state == M_REQ));
      check("irq_cause", 32'(irq_cause), 32'(m_cause));
      rd(2'd1, v); check("pending", v, {28'h0, m_pend});
      rd(2'd3, v); check("status", v, {28'h0, m_cause, m_state == M_REQ, m_state == M_SVC});
      rd(2'd0, v); check("enable", v, {28'h0, m_en});
      rd(2'd2, v); check("control", v, {31'h0, m_gie});
   endtask

   task automatic wr(input logic [1:0] a, input logic [31:0] d);
      reg_addr = a; reg_wdata = d; reg_we = 1'b1;
      step();
   endtask

   task automatic do_reset();
      logic [31:0] v;
      reset = 1'b1;
      #1;
      check("rst_req", 32'(irq_req), 32'h0);
      check("rst_cause", 32'(irq_cause), 32'h0);
      rd(2'd1, v); check("rst_pending", v, 32'h0);
      rd(2'd3, v); check("rst_status", v, 32'h0);
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      m_pend = 4'h0; m_en = 4'h0; m_gie = 1'b0; m_state = M_IDLE; m_cause = 2'd0;
      cyc = 0; h1.delete(); h2.delete();
   endtask

   initial begin
      logic [31:0] v;
      #2;
      do_reset();
      repeat (2) step();

      // Single timer source, full handshake
      wr(2'd0, 32'hF); wr(2'd2, 32'h1);
      tim2_irq = 1'b1; step();
      rd(2'd1, v); check("t2_pending", v, 32'h8);
      check("t2_req_early", 32'(irq_req), 32'h0);
      step();
      check("t2_req", 32'(irq_req), 32'h1);
      check("t2_cause", 32'(irq_cause), 32'h3);
      irq_ack = 1'b1; step();
      rd(2'd1, v); check("t2_ack_pending", v, 32'h0);
      rd(2'd3, v); check("t2_in_service", v, 32'hD);
      irq_done = 1'b1; step();
      rd(2'd3, v); check("t2_idle", 32'(v[1:0]), 32'h0);

      // Simultaneous timers: priority then follow-on request
      tim1_irq = 1'b1; tim2_irq = 1'b1; step();
      step();
      check("both_cause_first", 32'(irq_cause), 32'h2);
      irq_ack = 1'b1; step();
      irq_done = 1'b1; step();
      check("both_gap", 32'(irq_req), 32'h0);
      step();
      check("both_req_second", 32'(irq_req), 32'h1);
      check("both_cause_second", 32'(irq_cause), 32'h3);
      irq_ack = 1'b1; step();
      irq_done = 1'b1; step();

      // External pin held high: one edge only
      wr(2'd2, 32'h0);
      int_ext1 = 1'b1;
      repeat (LAT) step();
      rd(2'd1, v); check("ext1_not_yet", v, 32'h0);
      step();
      rd(2'd1, v); check("ext1_pending", v, 32'h1);
      wr(2'd1, 32'h1);
      repeat (4) step();
      rd(2'd1, v); check("ext1_no_retrigger", v, 32'h0);
      int_ext1 = 1'b0;
      repeat (3) step();
      int_ext1 = 1'b1;
      repeat (LAT + 1) step();
      rd(2'd1, v); check("ext1_second_edge", v, 32'h1);
      wr(2'd1, 32'h1);
      int_ext1 = 1'b0;
      step();

      // GIE gating
      tim1_irq = 1'b1; step();
      rd(2'd1, v); check("gie_off_pending", v, 32'h4);
      step();
      check("gie_off_noreq", 32'(irq_req), 32'h0);
      wr(2'd2, 32'h1);
      check("gie_on_same_cycle", 32'(irq_req), 32'h0);
      step();
      check("gie_on_req", 32'(irq_req), 32'h1);
      check("gie_on_cause", 32'(irq_cause), 32'h2);
      irq_ack = 1'b1; step();
      irq_done = 1'b1; step();

      // Committed request survives W1C / ENABLE / GIE changes
      int_ext2 = 1'b1;
      repeat (LAT + 2) step();
      check("commit_req", 32'(irq_req), 32'h1);
      check("commit_cause", 32'(irq_cause), 32'h1);
      wr(2'd1, 32'h2);
      check("commit_w1c_req", 32'(irq_req), 32'h1);
      check("commit_w1c_cause", 32'(irq_cause), 32'h1);
      tim1_irq = 1'b1; wr(2'd1, 32'h4);
      rd(2'd1, v); check("set_beats_w1c", v, 32'h4);
      wr(2'd0, 32'h0); wr(2'd2, 32'h0);
      check("commit_en_gie", 32'(irq_req), 32'h1);
      irq_ack = 1'b1; irq_done = 1'b1; step();
      rd(2'd3, v); check("ack_wins_over_done", v, 32'h5);
      wr(2'd0, 32'hF); wr(2'd2, 32'h1);
      step();
      check("no_nesting", 32'(irq_req), 32'h0);
      irq_done = 1'b1; step();
      step();
      check("after_done_cause", 32'(irq_cause), 32'h2);
      irq_ack = 1'b1; step();
      int_ext2 = 1'b0;
      tim2_irq = 1'b1; step();

      // Reset while in service
      do_reset();
      irq_done = 1'b1; step();
      rd(2'd3, v); check("post_reset_status", v, 32'h0);
      check("post_reset_req", 32'(irq_req), 32'h0);

      // Random phase
      wr(2'd0, 32'hF); wr(2'd2, 32'h1);
      for (int n = 0; n < 500; n++) begin
         tim1_irq = ($urandom_range(0, 6) == 0);
         tim2_irq = ($urandom_range(0, 6) == 0);
         if ($urandom_range(0, 9) == 0) int_ext1 = ~int_ext1;
         if ($urandom_range(0, 9) == 0) int_ext2 = ~int_ext2;
         if ($urandom_range(0, 4) == 0) begin
            reg_we = 1'b1;
            reg_addr = 2'($urandom_range(0, 3));
            reg_wdata = $urandom;
         end
         irq_ack = ($urandom_range(0, 2) == 0);
         irq_done = ($urandom_range(0, 2) == 0);
         step();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/interrupt_controller.md
# interrupt_controller

Fixed-priority interrupt arbiter and trap sequencer for the microcontroller. Collects the two external interrupt pins and the two timer compare events, latches them as pending, and presents one request at a time to the CPU core via a request/acknowledge/done handshake. Sits between the pins/timer blocks and the core's trap logic. Software configures it through a small word-addressed register window on the peripheral bus.

## Interface
- No parameters. Source count fixed at 4: id 0 = int_ext1, 1 = int_ext2, 2 = tim1, 3 = tim2.
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- int_ext1  in  1  external interrupt pin 1, rising-edge triggered, asynchronous to clk
- int_ext2  in  1  external interrupt pin 2, rising-edge triggered, asynchronous to clk
- tim1_irq  in  1  timer 1 compare event, single-cycle pulse, synchronous
- tim2_irq  in  1  timer 2 compare event, single-cycle pulse, synchronous
- reg_addr  in  2  register select
- reg_wdata  in  32  write data
- reg_we  in  1  write strobe, one write per cycle
- reg_rdata  out  32  read data, combinational from reg_addr
- irq_req  out  1  interrupt request to core
- irq_cause  out  2  id of requested/in-service source
- irq_ack  in  1  core has taken the trap
- irq_done  in  1  core has executed return-from-trap

## Operation
- Registers (unused bits read 0, writes ignored):
  - 0 ENABLE[3:0], R/W, per-source enable.
  - 1 PENDING[3:0], read; write-1-to-clear.
  - 2 CONTROL[0] = GIE, R/W, global enable.
  - 3 STATUS, read-only: [0] in_service, [1] requesting, [3:2] irq_cause.
- Pending set on external rising edge or timer pulse, regardless of ENABLE/GIE. Pending cleared by W1C or by ack of that source.
- Set and W1C of same bit in same cycle: set wins.
- Arbitration: lowest id wins among (PENDING & ENABLE), only when GIE=1.
- FSM:
  - IDLE: irq_req=0. If GIE and any (PENDING & ENABLE) -> REQUEST, latching winner into irq_cause.
  - REQUEST: irq_req=1, irq_cause held. Request is committed: later W1C, ENABLE or GIE changes do not withdraw it or change cause. On irq_ack -> SERVICE, clear PENDING[irq_cause].
  - SERVICE: irq_req=0, irq_cause held, no new request (no nesting). On irq_done -> IDLE.
- irq_ack outside REQUEST and irq_done outside SERVICE are ignored. irq_ack and irq_done together in REQUEST: ack taken, done ignored.
- Reset: ENABLE=0, PENDING=0, GIE=0, state IDLE, irq_req=0, irq_cause=0, edge-detect history=0. An input already high when reset releases does not produce an edge. Reset mid-SERVICE drops all state immediately.

## Timing
- Edge detection: pin sampled into flop s each edge. Rising edge = s & ~s_prev.
- Without synchronizer: first edge k where the pin is sampled high gives PENDING set at edge k+1.
- With synchronizer: PENDING set at edge k+3.
- Timer pulse high during cycle k gives PENDING set at edge k+1.
- PENDING & ENABLE & GIE true after edge m gives irq_req=1 after edge m+1. irq_req and irq_cause are registered.
- irq_ack sampled at edge n gives irq_req=0 and PENDING bit cleared after edge n. A pending source appearing during SERVICE raises irq_req no earlier than 1 cycle after returning to IDLE.
- Register writes take effect at the edge where reg_we is sampled.

## Configuration
- INTC_EXT_SYNC_EN defined: int_ext1/int_ext2 each pass through a 2-flop synchronizer before edge detection, adding 2 cycles of pin-to-pending latency.
- INTC_EXT_SYNC_EN undefined: single sampling flop only. Use only when pins are already synchronous.
- Timer paths are unaffected either way.

## Test plan
- Reset, then ENABLE=0xF, GIE=1, pulse tim2_irq for 1 cycle -> irq_req=1, irq_cause=3 one cycle after PENDING=0x8. irq_ack -> PENDING=0, STATUS.in_service=1. irq_done -> IDLE.
- tim1_irq and tim2_irq pulse in the same cycle -> cause 2 served first. After irq_done, cause 3 requested 1 cycle later.
- int_ext1 raised and held high -> exactly one pending set, at +1 cycle (macro off) or +3 cycles (macro on). No retrigger until the pin falls and rises again.
- GIE=0 with tim1 pulse -> PENDING=0x4 and no irq_req. Write GIE=1 -> irq_req one cycle later, cause 2.
- In REQUEST with cause 1: write PENDING=0x2 (W1C) -> irq_req stays 1, cause 1. Same-cycle tim1 pulse and W1C 0x4 -> PENDING[2]=1.
- Assert reset during SERVICE -> all outputs 0, PENDING 0, irq_done afterwards ignored.
